// File: rtl/key_extract_cfg_ctrl_pkg.sv
// Shared definitions for the key-extract control-path configurator:
// control header field offsets, table type codes and FSM state encoding.
package key_extract_cfg_ctrl_pkg;

  localparam int HDR_DPORT_LSB = 64;
  localparam int HDR_MODID_LSB = 112;
  localparam int HDR_TBL_LSB   = 124;
  localparam int HDR_IDX_LSB   = 128;

  localparam logic [3:0] TBL_KEY_OFF  = 4'd1;
  localparam logic [3:0] TBL_KEY_MASK = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FWD      = 2'd1,
    ST_WAIT_PAY = 2'd2,
    ST_DROP     = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/key_extract_cfg_ctrl_if.sv
// AXI-Stream style control bus (no tready: the ring never back-pressures).
interface key_extract_cfg_ctrl_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [USER_W-1:0]   tuser;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;

  modport master (output tdata, tuser, tkeep, tvalid, tlast);
  modport slave  (input  tdata, tuser, tkeep, tvalid, tlast);
endinterface

// File: rtl/key_extract_cfg_ctrl.sv
// Claims control packets addressed to this stage's key extractor and turns them
// into one-cycle table write strobes; every other packet is forwarded, one cycle late.
module key_extract_cfg_ctrl
  import key_extract_cfg_ctrl_pkg::*;
#(
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [4:0] STAGE_ID             = 5'd0,
  parameter logic [2:0] KEY_EX_ID            = 3'd1,
  parameter int         KEY_LEN              = 197,
  parameter int         KEY_OFF              = 18,
  parameter int         KEY_OFF_ADDR_WIDTH   = 4,
  parameter logic [15:0] CTRL_DPORT          = 16'hf1f2
) (
  input  logic                          clk,
  input  logic                          rst,
  key_extract_cfg_ctrl_if.slave         c_s_axis,
  key_extract_cfg_ctrl_if.master        c_m_axis,
  output logic                          key_off_wr_en,
  output logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_wr_addr,
  output logic [KEY_OFF-1:0]            key_off_wr_data,
  output logic                          key_mask_wr_en,
  output logic [KEY_OFF_ADDR_WIDTH-1:0] key_mask_wr_addr,
  output logic [KEY_LEN-1:0]            key_mask_wr_data,
  output logic [15:0]                   cfg_err_cnt
);

  localparam logic [7:0] MY_MOD_ID = {STAGE_ID, KEY_EX_ID};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  // Stage p0: header decode and FSM, combinational on the incoming beat
  logic [15:0]                   hdr_dport_p0;
  logic [7:0]                    hdr_mod_id_p0;
  logic [3:0]                    hdr_tbl_p0;
  logic [KEY_OFF_ADDR_WIDTH-1:0] hdr_idx_p0;
  logic                          hdr_claim_p0;

  assign hdr_dport_p0  = c_s_axis.tdata[HDR_DPORT_LSB +: 16];
  assign hdr_mod_id_p0 = c_s_axis.tdata[HDR_MODID_LSB +: 8];
  assign hdr_tbl_p0    = c_s_axis.tdata[HDR_TBL_LSB +: 4];
  assign hdr_idx_p0    = c_s_axis.tdata[HDR_IDX_LSB +: KEY_OFF_ADDR_WIDTH];
  assign hdr_claim_p0  = (hdr_dport_p0 == CTRL_DPORT) && (hdr_mod_id_p0 == MY_MOD_ID);

  cfg_state_e                    state_q, state_d;
  logic [3:0]                    tbl_q, tbl_d;
  logic [KEY_OFF_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                          vld_p0;
  logic                          off_wr_p0;
  logic                          mask_wr_p0;
  logic                          err_inc_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tbl_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tbl_d      = tbl_q;
    idx_d      = idx_q;
    vld_p0     = 1'b0;
    off_wr_p0  = 1'b0;
    mask_wr_p0 = 1'b0;
    err_inc_p0 = 1'b0;
    if (c_s_axis.tvalid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!hdr_claim_p0) begin
            vld_p0  = 1'b1;
            state_d = c_s_axis.tlast ? ST_IDLE : ST_FWD;
          end else if (c_s_axis.tlast) begin
            // A claimed header with no payload beat cannot carry a table entry.
            err_inc_p0 = 1'b1;
          end else if (hdr_tbl_p0 == TBL_KEY_OFF || hdr_tbl_p0 == TBL_KEY_MASK) begin
            tbl_d   = hdr_tbl_p0;
            idx_d   = hdr_idx_p0;
            state_d = ST_WAIT_PAY;
          end else begin
            err_inc_p0 = 1'b1;
            state_d    = ST_DROP;
          end
        end
        ST_FWD: begin
          vld_p0 = 1'b1;
          if (c_s_axis.tlast) state_d = ST_IDLE;
        end
        ST_WAIT_PAY: begin
          off_wr_p0  = (tbl_q == TBL_KEY_OFF);
          mask_wr_p0 = (tbl_q == TBL_KEY_MASK);
          state_d    = c_s_axis.tlast ? ST_IDLE : ST_DROP;
        end
        ST_DROP: begin
          if (c_s_axis.tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Stage p1: registered outputs; everything clears on reset so nothing stale leaks out
  logic                            vld_p1;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_p1;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_p1;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep_p1;
  logic                            tlast_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1           <= 1'b0;
      tdata_p1         <= '0;
      tuser_p1         <= '0;
      tkeep_p1         <= '0;
      tlast_p1         <= 1'b0;
      key_off_wr_en    <= 1'b0;
      key_off_wr_addr  <= '0;
      key_off_wr_data  <= '0;
      key_mask_wr_en   <= 1'b0;
      key_mask_wr_addr <= '0;
      key_mask_wr_data <= '0;
      cfg_err_cnt      <= '0;
    end else begin
      vld_p1         <= vld_p0;
      key_off_wr_en  <= off_wr_p0;
      key_mask_wr_en <= mask_wr_p0;
      if (vld_p0) begin
        tdata_p1 <= c_s_axis.tdata;
        tuser_p1 <= c_s_axis.tuser;
        tkeep_p1 <= c_s_axis.tkeep;
        tlast_p1 <= c_s_axis.tlast;
      end
      if (off_wr_p0) begin
        key_off_wr_addr <= idx_q;
        key_off_wr_data <= c_s_axis.tdata[KEY_OFF-1:0];
      end
      if (mask_wr_p0) begin
        key_mask_wr_addr <= idx_q;
        key_mask_wr_data <= c_s_axis.tdata[KEY_LEN-1:0];
      end
      if (err_inc_p0) cfg_err_cnt <= sat_inc(cfg_err_cnt);
    end
  end

  assign c_m_axis.tvalid = vld_p1;
  assign c_m_axis.tdata  = tdata_p1;
  assign c_m_axis.tuser  = tuser_p1;
  assign c_m_axis.tkeep  = tkeep_p1;
  assign c_m_axis.tlast  = tlast_p1;

endmodule

// File: tb/tb_key_extract_cfg_ctrl.sv
// Directed bench for key_extract_cfg_ctrl: a packet-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_key_extract_cfg_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_extract_cfg_ctrl_if #(.DATA_W(256), .USER_W(128)) s_if ();
  key_extract_cfg_ctrl_if #(.DATA_W(256), .USER_W(128)) m_if ();

  logic         key_off_wr_en;
  logic [3:0]   key_off_wr_addr;
  logic [17:0]  key_off_wr_data;
  logic         key_mask_wr_en;
  logic [3:0]   key_mask_wr_addr;
  logic [196:0] key_mask_wr_data;
  logic [15:0]  cfg_err_cnt;

  key_extract_cfg_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .c_s_axis         (s_if),
    .c_m_axis         (m_if),
    .key_off_wr_en    (key_off_wr_en),
    .key_off_wr_addr  (key_off_wr_addr),
    .key_off_wr_data  (key_off_wr_data),
    .key_mask_wr_en   (key_mask_wr_en),
    .key_mask_wr_addr (key_mask_wr_addr),
    .key_mask_wr_data (key_mask_wr_data),
    .cfg_err_cnt      (cfg_err_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks packets, not FSM states
  logic         m_in_pkt, m_fwd, m_ok;
  logic [3:0]   m_tbl, m_idx;
  int           m_beat;
  logic [15:0]  m_err;
  logic         exp_vld, exp_off_en, exp_mask_en;
  logic [255:0] exp_data;
  logic [127:0] exp_user;
  logic [31:0]  exp_keep;
  logic         exp_last;
  logic [3:0]   exp_addr;
  logic [196:0] exp_wdata;

  always @(posedge clk or posedge rst) begin : model
    logic fwd, ok, claim;
    logic [3:0] tb, ix;
    int bn;
    if (rst) begin
      m_in_pkt <= 1'b0; m_fwd <= 1'b0; m_ok <= 1'b0; m_tbl <= '0; m_idx <= '0;
      m_beat <= 0; m_err <= '0;
      exp_vld <= 1'b0; exp_off_en <= 1'b0; exp_mask_en <= 1'b0;
      exp_data <= '0; exp_user <= '0; exp_keep <= '0; exp_last <= 1'b0;
      exp_addr <= '0; exp_wdata <= '0;
    end else begin
      fwd = m_fwd; ok = m_ok; tb = m_tbl; ix = m_idx; bn = m_beat + 1;
      exp_vld <= 1'b0; exp_off_en <= 1'b0; exp_mask_en <= 1'b0;
      if (s_if.tvalid) begin
        if (!m_in_pkt) begin
          claim = (s_if.tdata[79:64] == 16'hf1f2) && (s_if.tdata[119:112] == 8'h01);
          tb  = s_if.tdata[127:124];
          ix  = s_if.tdata[131:128];
          fwd = !claim;
          ok  = claim && (tb == 4'd1 || tb == 4'd2) && !s_if.tlast;
          bn  = 0;
          if (claim && !ok && m_err != 16'hffff) m_err <= m_err + 16'd1;
        end
        m_fwd <= fwd; m_ok <= ok; m_tbl <= tb; m_idx <= ix; m_beat <= bn;
        m_in_pkt <= !s_if.tlast;
        if (fwd) begin
          exp_vld  <= 1'b1;
          exp_data <= s_if.tdata; exp_user <= s_if.tuser;
          exp_keep <= s_if.tkeep; exp_last <= s_if.tlast;
        end
        if (ok && bn == 1) begin
          exp_addr <= ix;
          if (tb == 4'd1) begin
            exp_off_en <= 1'b1;
            exp_wdata  <= {179'd0, s_if.tdata[17:0]};
          end else begin
            exp_mask_en <= 1'b1;
            exp_wdata   <= s_if.tdata[196:0];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tvalid", {255'd0, m_if.tvalid}, {255'd0, exp_vld});
    if (exp_vld) begin
      chk("m_tdata", m_if.tdata, exp_data);
      chk("m_tuser", {128'd0, m_if.tuser}, {128'd0, exp_user});
      chk("m_tkeep", {224'd0, m_if.tkeep}, {224'd0, exp_keep});
      chk("m_tlast", {255'd0, m_if.tlast}, {255'd0, exp_last});
    end
    chk("off_wr_en", {255'd0, key_off_wr_en}, {255'd0, exp_off_en});
    chk("mask_wr_en", {255'd0, key_mask_wr_en}, {255'd0, exp_mask_en});
    chk("one_hot_wr", {255'd0, key_off_wr_en & key_mask_wr_en}, 256'd0);
    if (exp_off_en) begin
      chk("off_wr_addr", {252'd0, key_off_wr_addr}, {252'd0, exp_addr});
      chk("off_wr_data", {238'd0, key_off_wr_data}, {59'd0, exp_wdata});
    end
    if (exp_mask_en) begin
      chk("mask_wr_addr", {252'd0, key_mask_wr_addr}, {252'd0, exp_addr});
      chk("mask_wr_data", {59'd0, key_mask_wr_data}, {59'd0, exp_wdata});
    end
    chk("cfg_err_cnt", {240'd0, cfg_err_cnt}, {240'd0, m_err});
  end

  function automatic logic [255:0] mk_hdr(input logic [15:0] dport, input logic [7:0] mod,
                                          input logic [3:0] tbl, input logic [3:0] idx);
    logic [255:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d[79:64]   = dport;
    d[119:112] = mod;
    d[127:124] = tbl;
    d[131:128] = idx;
    return d;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one beat; on return the DUT has registered it and its outputs are settled.
  task automatic beat(input logic [255:0] d, input logic l);
    s_if.tdata  = d;
    s_if.tuser  = {$urandom, $urandom, $urandom, $urandom};
    s_if.tkeep  = $urandom;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [255:0] d;

  initial begin
    rst = 1'b1;
    s_if.tdata = '0; s_if.tuser = '0; s_if.tkeep = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {255'd0, m_if.tvalid}, 256'd0);
    chk("rst_off_en", {255'd0, key_off_wr_en}, 256'd0);
    chk("rst_err", {240'd0, cfg_err_cnt}, 256'd0);
    rst = 1'b0;
    idle();

    // 1. claimed key-offset write
    beat(mk_hdr(16'hf1f2, 8'h01, 4'd1, 4'd3), 1'b0);
    chk("t1_hdr_not_fwd", {255'd0, m_if.tvalid}, 256'd0);
    d = rnd256(); d[17:0] = 18'h2A5C5;
    beat(d, 1'b1);
    chk("t1_off_en", {255'd0, key_off_wr_en}, 256'd1);
    chk("t1_off_addr", {252'd0, key_off_wr_addr}, 256'd3);
    chk("t1_off_data", {238'd0, key_off_wr_data}, 256'h2A5C5);
    chk("t1_pay_not_fwd", {255'd0, m_if.tvalid}, 256'd0);
    idle();
    chk("t1_off_en_1cyc", {255'd0, key_off_wr_en}, 256'd0);

    // 2. claimed key-mask write, 4-beat packet
    beat(mk_hdr(16'hf1f2, 8'h01, 4'd2, 4'd15), 1'b0);
    beat({256{1'b1}}, 1'b0);
    chk("t2_mask_en", {255'd0, key_mask_wr_en}, 256'd1);
    chk("t2_mask_addr", {252'd0, key_mask_wr_addr}, 256'd15);
    chk("t2_mask_data", {59'd0, key_mask_wr_data}, {59'd0, {197{1'b1}}});
    beat(rnd256(), 1'b0);
    chk("t2_b3_no_wr", {255'd0, key_mask_wr_en}, 256'd0);
    beat(rnd256(), 1'b1);
    chk("t2_b4_dropped", {255'd0, m_if.tvalid}, 256'd0);

    // 3. foreign packet (mod_id mismatch) forwarded bit-exact
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? mk_hdr(16'hf1f2, 8'h09, 4'd1, 4'd2) : rnd256();
      beat(d, i == 2);
      chk("t3_fwd_vld", {255'd0, m_if.tvalid}, 256'd1);
      chk("t3_fwd_data", m_if.tdata, d);
      chk("t3_fwd_last", {255'd0, m_if.tlast}, (i == 2) ? 256'd1 : 256'd0);
    end
    idle();
    chk("t3_fwd_end", {255'd0, m_if.tvalid}, 256'd0);

    // 4. malformed: bad table type, then header-only claimed packet
    beat(mk_hdr(16'hf1f2, 8'h01, 4'd3, 4'd1), 1'b0);
    beat(rnd256(), 1'b1);
    beat(mk_hdr(16'hf1f2, 8'h01, 4'd1, 4'd4), 1'b1);
    idle();
    chk("t4_err_cnt", {240'd0, cfg_err_cnt}, 256'd2);
    chk("t4_no_off_wr", {255'd0, key_off_wr_en}, 256'd0);

    // 5. claimed packet with gaps, then back-to-back foreign packets
    beat(mk_hdr(16'hf1f2, 8'h01, 4'd2, 4'd7), 1'b0);
    idle(); idle();
    d = rnd256();
    beat(d, 1'b0);
    chk("t5_mask_en", {255'd0, key_mask_wr_en}, 256'd1);
    chk("t5_mask_addr", {252'd0, key_mask_wr_addr}, 256'd7);
    chk("t5_mask_data", {59'd0, key_mask_wr_data}, {59'd0, d[196:0]});
    idle();
    beat(rnd256(), 1'b1);
    d = mk_hdr(16'h1234, 8'h01, 4'd1, 4'd0);
    beat(d, 1'b0);
    chk("t5_dport_fwd", m_if.tdata, d);
    beat(rnd256(), 1'b1);
    chk("t5_fwd_last", {255'd0, m_if.tlast}, 256'd1);

    // 6. asynchronous reset during a forwarded packet
    beat(mk_hdr(16'h0000, 8'h01, 4'd1, 4'd0), 1'b0);
    chk("t6_fwd_vld", {255'd0, m_if.tvalid}, 256'd1);
    s_if.tdata = rnd256(); s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_vld", {255'd0, m_if.tvalid}, 256'd0);
    chk("t6_rst_data", m_if.tdata, 256'd0);
    chk("t6_rst_err", {240'd0, cfg_err_cnt}, 256'd0);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    rst = 1'b0;
    idle();
    beat(mk_hdr(16'hf1f2, 8'h01, 4'd1, 4'd5), 1'b0);
    chk("t6_hdr_claimed", {255'd0, m_if.tvalid}, 256'd0);
    d = rnd256(); d[17:0] = 18'h155AA;
    beat(d, 1'b1);
    chk("t6_off_en", {255'd0, key_off_wr_en}, 256'd1);
    chk("t6_off_addr", {252'd0, key_off_wr_addr}, 256'd5);
    chk("t6_off_data", {238'd0, key_off_wr_data}, 256'h155AA);
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
